// File: rtl/nibble_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_add_ctrl
//
// Adds two NIBBLES*4-bit operands by stepping an external combinational
// 4-bit adder slice one nibble per clock, least significant nibble first.
// The carry from each step is registered and fed back as the carry-in of the
// next step. The collected result is offered on a valid/ready output
// together with the final carry and a two's-complement overflow flag.
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand request valid
//   in_ready   controller can accept operands (IDLE only)
//   in_a/in_b  W-bit operands, in_cin carry into the LSB nibble
//   add_a/b    nibble of A/B driven to the adder slice (0 outside RUN)
//   add_cin    carry driven to the adder slice (0 outside RUN)
//   add_sum    sum nibble returned by the slice in the same cycle
//   add_cout   carry returned by the slice in the same cycle
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts the result
//   out_sum    W-bit sum, out_cout carry out of the MSB nibble
//   out_ovf    signed overflow of the W-bit addition
//   busy       high in RUN or DONE
// ---------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_cin,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout,
    output logic                   out_ovf,
    output logic                   busy
);

    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    generate
        if (NIBBLES < 1 || NIBBLES > 16) begin : g_bad_param
            $error("nibble_serial_add_ctrl: NIBBLES must be in 1..16");
        end
    endgenerate

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e                    state_q;
    logic [NIBBLES-1:0][3:0]   a_q;
    logic [NIBBLES-1:0][3:0]   b_q;
    logic [NIBBLES-1:0][3:0]   sum_q;
    logic [NIBBLES-1:0][3:0]   sum_d;
    logic                      carry_q;
    logic [IdxW-1:0]           idx_q;

    // Registered outputs
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic                      busy_q;
    logic [NIBBLES-1:0][3:0]   out_sum_q;
    logic                      out_cout_q;
    logic                      out_ovf_q;

    // Sum register with the current nibble from the slice merged in; used both
    // for the running update and for loading the final result on the last step.
    always_comb begin
        sum_d = sum_q;
        if (state_q == StRun) begin
            sum_d[idx_q] = add_sum;
        end
    end

    // Slice inputs are forced to zero outside RUN so the adder sees no toggling.
    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state_q == StRun) begin
            add_a   = a_q[idx_q];
            add_b   = b_q[idx_q];
            add_cin = carry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q        <= in_a;
                        b_q        <= in_b;
                        carry_q    <= in_cin;
                        sum_q      <= '0;
                        idx_q      <= '0;
                        state_q    <= StRun;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end

                StRun: begin
                    sum_q   <= sum_d;
                    carry_q <= add_cout;
                    if (idx_q == LastIdx) begin
                        // Last nibble: present the result from the merged sum
                        // so out_* are valid in the first DONE cycle.
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                        out_sum_q   <= sum_d;
                        out_cout_q  <= add_cout;
                        out_ovf_q   <= (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                                       (sum_d[NIBBLES-1][3] != a_q[NIBBLES-1][3]);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end

                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        out_sum_q   <= '0;
                        out_cout_q  <= 1'b0;
                        out_ovf_q   <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that adds two wide operands, NIBBLES*4 bits each, by driving an external combinational 4-bit adder slice one nibble per clock, LSB nibble first.
- Sits directly upstream and downstream of the 4-bit adder: it feeds the adder's a, b and cin inputs and consumes its sum and cout.
- Collects the result into a wide register and presents it on a valid/ready output.
- Adds no arithmetic of its own except the signed-overflow flag.

Parameters:
NIBBLES, 4, operand width in 4-bit nibbles; legal range 1..16; operand width W = 4*NIBBLES.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
in_valid  input  1  operand request valid
in_ready  output  1  controller can accept operands
in_a  input  W  operand A
in_b  input  W  operand B
in_cin  input  1  carry into the LSB nibble
add_a  output  4  nibble of A driven to the adder slice
add_b  output  4  nibble of B driven to the adder slice
add_cin  output  1  carry driven to the adder slice
add_sum  input  4  sum returned by the adder slice (combinational, same cycle)
add_cout  input  1  carry returned by the adder slice (combinational, same cycle)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  W  full-width sum
out_cout  output  1  carry out of the MSB nibble
out_ovf  output  1  two's-complement signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: rst_n low at a rising edge puts the FSM in IDLE and clears all internal registers: a_reg, b_reg, sum_reg, carry_reg, idx. Reset overrides any in-flight operation and any pending result with no partial output. While in reset or IDLE:
  - in_ready=1
  - out_valid=0, busy=0
  - out_sum=0, out_cout=0, out_ovf=0
  - add_a=0, add_b=0, add_cin=0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_a->a_reg, in_b->b_reg, in_cin->carry_reg; set idx=0, clear sum_reg; go to RUN.
- RUN:
  - in_ready=0.
  - Combinational drive: add_a=a_reg[4*idx+3:4*idx], add_b=b_reg[4*idx+3:4*idx], add_cin=carry_reg.
  - Each edge: sum_reg[4*idx+3:4*idx]<=add_sum, carry_reg<=add_cout, idx<=idx+1.
  - When idx==NIBBLES-1, go to DONE on that edge.
  - RUN lasts exactly NIBBLES cycles.
- DONE:
  - out_valid=1; out_sum=sum_reg; out_cout=carry_reg.
  - out_ovf=(a_reg[W-1]==b_reg[W-1]) && (sum_reg[W-1]!=a_reg[W-1]).
  - Outputs hold stable while out_ready=0.
  - On out_valid&&out_ready, go to IDLE; outputs return to 0 in the next cycle.
  - in_ready=0 in DONE; a new operand is not accepted in the same cycle as the result handshake.
- Latency: operands accepted at edge E; out_valid rises after edge E+NIBBLES. Minimum issue interval is NIBBLES+2 cycles.
- add_* outputs are 0 in IDLE and DONE, so the adder slice sees no toggling when idle.
- in_a, in_b and in_cin are ignored outside the IDLE handshake; input changes during RUN have no effect.
- NIBBLES=1: RUN lasts one cycle, then DONE.
- idx width is clog2(NIBBLES) with a minimum of 1; idx never wraps past NIBBLES-1.
- Widths: sum is W bits with carry separate; no truncation or extension occurs.

Test Plan:
- NIBBLES=4, the adder slice modelled as an ideal 4-bit adder. A=0xFFFF, B=0x0001, cin=0 -> out_sum=0x0000, out_cout=1, out_ovf=0. out_valid rises exactly 4 cycles after the accept edge.
- A=0x7FFF, B=0x0001, cin=0 -> out_sum=0x8000, out_cout=0, out_ovf=1. Check add_a per RUN cycle = F,F,F,7 and add_cin per RUN cycle = 0,1,1,1.
- A=0x1234, B=0x4321, cin=1 -> out_sum=0x5556, out_cout=0, out_ovf=0. Hold out_ready=0 for 5 cycles: out_valid and out_sum stay stable and in_ready stays 0. Pulse out_ready: next cycle is IDLE with in_ready=1.
- Reset mid-operation: accept A=0xAAAA, B=0x5555, then assert rst_n=0 in the 2nd RUN cycle -> next cycle in IDLE with all outputs 0. A fresh request A=0x0003, B=0x0004 -> out_sum=0x0007 with no residue from the aborted operation.
- NIBBLES=1: A=0x8, B=0x8, cin=0 -> out_sum=0x0, out_cout=1, out_ovf=1, out_valid one cycle after accept. Back-to-back requests with in_valid held high are accepted every 3 cycles.
